// File: rtl/regfile_sb.sv
// Two-write, two-read register file with per-register pending (busy) bits and a registered debug port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   wa0,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd0,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   ra0,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            busy0,
  output logic            busy1,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [31:0] NREGS_U = 32'(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] dbg_q, dbg_d;

  logic wen0, wen1, setOk;
  logic [XLEN-1:0] rdStored0, rdStored1;
  logic busyStored0, busyStored1;

  // An address is live when it exists and is not the hardwired zero register.
  function automatic logic addrOk(input logic [AW-1:0] a);
    return ({{(32-AW){1'b0}}, a} < NREGS_U) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wen0  = we0 && addrOk(wa0) && !rst;
  assign wen1  = we1 && addrOk(wa1) && !rst;
  assign setOk = sb_set && addrOk(sb_addr) && !rst;

  // Port 1 is applied last so it wins a same-address conflict; a set beats any clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wen0) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (wen1) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (setOk) busy_d[sb_addr] = 1'b1;
  end

  assign rdStored0   = addrOk(ra0) ? regs_q[ra0] : '0;
  assign rdStored1   = addrOk(ra1) ? regs_q[ra1] : '0;
  assign busyStored0 = addrOk(ra0) && busy_q[ra0];
  assign busyStored1 = addrOk(ra1) && busy_q[ra1];
  assign dbg_d       = addrOk(dbg_addr) ? regs_q[dbg_addr] : '0;

  always_comb begin
    rd0   = rdStored0;
    rd1   = rdStored1;
    busy0 = busyStored0;
    busy1 = busyStored1;
`ifdef REGFILE_BYPASS_EN
    if (wen1 && (wa1 == ra0)) begin
      rd0   = wd1;
      busy0 = setOk && (sb_addr == ra0);
    end else if (wen0 && (wa0 == ra0)) begin
      rd0   = wd0;
      busy0 = setOk && (sb_addr == ra0);
    end
    if (wen1 && (wa1 == ra1)) begin
      rd1   = wd1;
      busy1 = setOk && (sb_addr == ra1);
    end else if (wen0 && (wa0 == ra1)) begin
      rd1   = wd0;
      busy1 = setOk && (sb_addr == ra1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end

  assign dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: default, ZERO_REG=0 and a 6-entry instance share stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, sb_set;
  logic [4:0]  wa0, wa1, ra0, ra1, sb_addr, dbg_addr;
  logic [31:0] wd0, wd1;

  logic [31:0] rd0, rd1, dbg_data;
  logic        busy0, busy1;
  logic [31:0] nz_rd0, nz_rd1, nz_dbg;
  logic        nz_busy0, nz_busy1;
  logic [31:0] sm_rd0, sm_rd1, sm_dbg;
  logic        sm_busy0, sm_busy1;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy0(busy0), .busy1(busy1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_sb #(.ZERO_REG(0)) dutNz (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .ra0(ra0), .ra1(ra1), .rd0(nz_rd0), .rd1(nz_rd1),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy0(nz_busy0), .busy1(nz_busy1),
    .dbg_addr(dbg_addr), .dbg_data(nz_dbg)
  );

  // Six entries on a 3-bit address: addresses 6 and 7 exist on the bus but not in storage.
  regfile_sb #(.NREGS(6)) dutSm (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0[2:0]), .wa1(wa1[2:0]),
    .wd0(wd0), .wd1(wd1), .ra0(ra0[2:0]), .ra1(ra1[2:0]), .rd0(sm_rd0), .rd1(sm_rd1),
    .sb_set(sb_set), .sb_addr(sb_addr[2:0]), .busy0(sm_busy0), .busy1(sm_busy1),
    .dbg_addr(dbg_addr[2:0]), .dbg_data(sm_dbg)
  );

  task automatic expectValue(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbQ.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One rising edge, then leave 1ns so outputs are sampled away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    we0 = 0; we1 = 0; sb_set = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1;
    clearInputs();
    ra0 = 0; ra1 = 0; sb_addr = 0; dbg_addr = 0;
    applyStimulus();
    applyStimulus();
    ra0 = 5; ra1 = 9;
    #1;
    expectValue("reset_rd0", 32'h0);   checkOutput(rd0);
    expectValue("reset_rd1", 32'h0);   checkOutput(rd1);
    expectValue("reset_busy0", 32'h0); checkOutput({31'b0, busy0});
    expectValue("reset_dbg", 32'h0);   checkOutput(dbg_data);
    rst = 0;

    // Reset then write, with debug snapshot of the same register.
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; dbg_addr = 5;
    expectValue("dbg_pre_edge_value", 32'h0);
    expectValue("rd0_after_write", 32'hDEADBEEF);
    expectValue("dbg_one_edge_later", 32'hDEADBEEF);
    applyStimulus();
    checkOutput(dbg_data);
    clearInputs(); ra0 = 5;
    #1 checkOutput(rd0);
    applyStimulus();
    checkOutput(dbg_data);

    // Same-address dual write: port 1 wins; small instance ignores address 7.
    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11; wd1 = 32'h22;
    expectValue("conflict_port1_wins", 32'h22);
    expectValue("small_out_of_range_rd", 32'h0);
    applyStimulus();
    clearInputs(); ra0 = 7;
    #1 checkOutput(rd0);
    checkOutput(sm_rd0);

    we0 = 1; we1 = 1; wa0 = 3; wa1 = 4; wd0 = 32'h33; wd1 = 32'h44;
    expectValue("dual_write_reg3", 32'h33);
    expectValue("dual_write_reg4", 32'h44);
    expectValue("small_dual_write_reg4", 32'h44);
    applyStimulus();
    clearInputs(); ra0 = 3; ra1 = 4;
    #1 checkOutput(rd0);
    checkOutput(rd1);
    checkOutput(sm_rd1);

    // Register 0: hardwired zero by default, ordinary with ZERO_REG=0.
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0;
    expectValue("zero_reg_rd0", 32'h0);
    expectValue("zero_reg_busy0", 32'h0);
    expectValue("nz_reg0_rd0", 32'hFFFFFFFF);
    expectValue("nz_reg0_busy0", 32'h1);
    applyStimulus();
    clearInputs(); ra0 = 0;
    #1 checkOutput(rd0);
    checkOutput({31'b0, busy0});
    checkOutput(nz_rd0);
    checkOutput({31'b0, nz_busy0});

    // Scoreboard set, set-beats-write, then a plain write clears.
    sb_set = 1; sb_addr = 9;
    expectValue("busy_after_set", 32'h1);
    applyStimulus();
    clearInputs(); ra0 = 9;
    #1 checkOutput({31'b0, busy0});
    we0 = 1; wa0 = 9; wd0 = 32'h99; sb_set = 1; sb_addr = 9;
    expectValue("busy_set_wins_over_write", 32'h1);
    expectValue("write_with_set_data", 32'h99);
    applyStimulus();
    clearInputs();
    #1 checkOutput({31'b0, busy0});
    checkOutput(rd0);
    we1 = 1; wa1 = 9; wd1 = 32'h98;
`ifdef REGFILE_BYPASS_EN
    expectValue("busy_during_write_cycle", 32'h0);
`else
    expectValue("busy_during_write_cycle", 32'h1);
`endif
    expectValue("busy_cleared_by_write", 32'h0);
    expectValue("rd0_after_clear_write", 32'h98);
    #1 checkOutput({31'b0, busy0});
    applyStimulus();
    clearInputs();
    #1 checkOutput({31'b0, busy0});
    checkOutput(rd0);

    // Set to address 6: real in the big file, nonexistent in the small one.
    sb_set = 1; sb_addr = 6;
    expectValue("busy_reg6", 32'h1);
    expectValue("small_busy_out_of_range", 32'h0);
    applyStimulus();
    clearInputs(); ra0 = 6;
    #1 checkOutput({31'b0, busy0});
    checkOutput({31'b0, sm_busy0});

    // Same-cycle read of a register being written.
    we0 = 1; wa0 = 12; wd0 = 32'h1212;
    applyStimulus();
    clearInputs(); ra0 = 12;
    we1 = 1; wa1 = 12; wd1 = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    expectValue("bypass_same_cycle", 32'hA5A5A5A5);
`else
    expectValue("bypass_same_cycle", 32'h1212);
`endif
    expectValue("after_bypass_edge", 32'hA5A5A5A5);
    #1 checkOutput(rd0);
    applyStimulus();
    clearInputs();
    #1 checkOutput(rd0);

    // Load registers 1..4 with busy set, then reset between edges.
    for (int i = 1; i <= 4; i++) begin
      we0 = 1; wa0 = 5'(i); wd0 = 32'(i) * 32'h101; sb_set = 1; sb_addr = 5'(i);
      applyStimulus();
    end
    clearInputs(); ra0 = 2; ra1 = 4; dbg_addr = 3;
    expectValue("loaded_rd0", 32'h202);
    expectValue("loaded_busy1", 32'h1);
    expectValue("loaded_dbg", 32'h303);
    applyStimulus();
    checkOutput(rd0);
    checkOutput({31'b0, busy1});
    checkOutput(dbg_data);
    #2 rst = 1;
    expectValue("async_rst_rd0", 32'h0);
    expectValue("async_rst_rd1", 32'h0);
    expectValue("async_rst_busy0", 32'h0);
    expectValue("async_rst_busy1", 32'h0);
    expectValue("async_rst_dbg", 32'h0);
    #1 checkOutput(rd0);
    checkOutput(rd1);
    checkOutput({31'b0, busy0});
    checkOutput({31'b0, busy1});
    checkOutput(dbg_data);
    we0 = 1; wa0 = 2; wd0 = 32'hBAD; sb_set = 1; sb_addr = 4;
    applyStimulus();
    rst = 0;
    clearInputs();
    expectValue("write_during_rst_dropped", 32'h0);
    expectValue("set_during_rst_dropped", 32'h0);
    expectValue("dbg_after_rst", 32'h0);
    #1 checkOutput(rd0);
    checkOutput({31'b0, busy1});
    applyStimulus();
    checkOutput(dbg_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
